// File: rtl/forward_hazard_unit_if.sv
// Decode-to-hazard-unit bundle: decode drives the candidate instruction,
// the unit answers with stall, the registered bypass selects and a stall counter.
interface forward_hazard_unit_if #(
    parameter int ADDR_W = 5,
    parameter int NSRC   = 2,
    parameter int DEPTH  = 3
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(DEPTH + 1);

    logic                    id_valid;
    logic [NSRC*ADDR_W-1:0]  id_src;
    logic [NSRC-1:0]         id_src_used;
    logic [ADDR_W-1:0]       id_rd;
    logic                    id_regwrite;
    logic [LAT_W-1:0]        id_lat;
    logic                    flush;
    logic                    stall;
    logic [NSRC*SEL_W-1:0]   fwd_sel_q;
    logic [15:0]             stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_rd, id_regwrite, id_lat, flush,
        input  stall, fwd_sel_q, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_rd, id_regwrite, id_lat, flush,
        output stall, fwd_sel_q, stall_cnt
    );
endinterface

// File: rtl/forward_hazard_unit.sv
// Operand-forwarding and load-use hazard unit: a shifting scoreboard of recent
// producers decides, per source, whether to bypass, read the register file or stall.
module forward_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int NSRC   = 2,
    parameter int DEPTH  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    forward_hazard_unit_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic [LAT_W-1:0]  cnt;   // cycles until the result reaches a bypassable register
    } entry_t;

    entry_t [DEPTH-1:0]     sb_q, sb_d;
    logic [NSRC*SEL_W-1:0]  fwd_sel_q, fwd_sel_d, sel_next;
    logic [15:0]            stall_cnt_q, stall_cnt_d;
    logic [NSRC-1:0]        hazard;
    logic [ADDR_W-1:0]      src;
    logic [LAT_W-1:0]       lat_clip;
    logic                   found;
    logic                   stall;
    logic                   take;

    // Youngest-match search: entry 0 is the most recent producer, so the first hit wins.
    always_comb begin
        // NOTE: blocking assignments with defaults first keep this purely combinational (no latches).
        hazard   = '0;
        sel_next = '0;
        src      = '0;
        found    = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            src   = bus.id_src[i*ADDR_W +: ADDR_W];
            found = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (!found && bus.id_src_used[i] && sb_q[j].v &&
                    (sb_q[j].rd == src) && (src != '0)) begin
                    found = 1'b1;
                    if (sb_q[j].cnt > LAT_W'(1)) hazard[i] = 1'b1;
                    else                         sel_next[i*SEL_W +: SEL_W] = SEL_W'(j + 1);
                end
            end
        end
    end

    always_comb begin
        stall = bus.id_valid & ~bus.flush & (|hazard);
        take  = bus.id_valid & ~stall & ~bus.flush;

        if (bus.id_lat == '0)                    lat_clip = LAT_W'(1);
        else if (bus.id_lat > LAT_W'(DEPTH))     lat_clip = LAT_W'(DEPTH);
        else                                     lat_clip = bus.id_lat;

        // A stalled or flushed slot still shifts in as an invalid bubble.
        sb_d       = '0;
        sb_d[0].v  = take & bus.id_regwrite & (bus.id_rd != '0);
        sb_d[0].rd = bus.id_rd;
        sb_d[0].cnt = lat_clip;
        for (int j = 1; j < DEPTH; j++) begin
            sb_d[j] = sb_q[j-1];
            if (sb_q[j-1].cnt != '0) sb_d[j].cnt = sb_q[j-1].cnt - LAT_W'(1);
        end

        fwd_sel_d   = take ? sel_next : '0;
        stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the scoreboard is a handful of flops, and stale valid bits would create
            // phantom hazards, so the whole array is reset rather than just the valid bits.
            sb_q        <= '0;
            fwd_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            fwd_sel_q   <= fwd_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.fwd_sel_q = fwd_sel_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: directed cases on the default build, a randomized
// sweep on a 3-source/4-deep build against a reference model, and counter saturation.
module tb_forward_hazard_unit;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    forward_hazard_unit_if #(.ADDR_W(5), .NSRC(2), .DEPTH(3))  if0 ();
    forward_hazard_unit_if #(.ADDR_W(5), .NSRC(3), .DEPTH(4))  if1 ();
    forward_hazard_unit_if #(.ADDR_W(5), .NSRC(1), .DEPTH(31)) if2 ();

    forward_hazard_unit #(.ADDR_W(5), .NSRC(2), .DEPTH(3))  u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    forward_hazard_unit #(.ADDR_W(5), .NSRC(3), .DEPTH(4))  u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    forward_hazard_unit #(.ADDR_W(5), .NSRC(1), .DEPTH(31)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    // Reference model for u1: slot k holds the instruction issued k cycles before decode.
    localparam int D1 = 4;
    localparam int S1 = 3;
    logic       h_v   [1:D1];
    logic [4:0] h_rd  [1:D1];
    int         h_lat [1:D1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check(e.tag, 32'(if0.fwd_sel_q), e.exp);
        end
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check(e.tag, 32'(if1.fwd_sel_q), e.exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [1:0] used, input logic [4:0] rd, input logic rw,
                          input logic [1:0] lat, input logic fl);
        if0.id_valid    = v;
        if0.id_src      = {s1, s0};
        if0.id_src_used = used;
        if0.id_rd       = rd;
        if0.id_regwrite = rw;
        if0.id_lat      = lat;
        if0.flush       = fl;
    endtask

    task automatic step0(input string tag, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [1:0] used, input logic [4:0] rd, input logic rw,
                         input logic [1:0] lat, input logic fl,
                         input logic exp_stall, input logic [3:0] exp_sel);
        drive0(v, s0, s1, used, rd, rw, lat, fl);
        #1;
        check({tag, "_stall"}, 32'(if0.stall), 32'(exp_stall));
        q0.push_back('{tag: {tag, "_sel"}, exp: 32'(exp_sel)});
        tick();
    endtask

    // A producer issued k cycles ago with latency L can be bypassed next cycle iff L <= k.
    task automatic model_eval(output logic st, output logic take, output logic [S1*3-1:0] sel);
        logic [S1-1:0] haz;
        logic [4:0]    s;
        bit            done;
        haz = '0;
        sel = '0;
        for (int i = 0; i < S1; i++) begin
            s    = if1.id_src[i*5 +: 5];
            done = 0;
            for (int k = 1; k <= D1; k++) begin
                if (!done && if1.id_src_used[i] && h_v[k] && h_rd[k] == s && s != 5'd0) begin
                    done = 1;
                    if (h_lat[k] > k) haz[i] = 1'b1;
                    else              sel[i*3 +: 3] = 3'(k);
                end
            end
        end
        st   = if1.id_valid & ~if1.flush & (|haz);
        take = if1.id_valid & ~st & ~if1.flush;
    endtask

    task automatic model_shift(input logic take);
        int l;
        for (int k = D1; k > 1; k--) begin
            h_v[k]   = h_v[k-1];
            h_rd[k]  = h_rd[k-1];
            h_lat[k] = h_lat[k-1];
        end
        l        = int'(if1.id_lat);
        h_v[1]   = take & if1.id_regwrite & (if1.id_rd != 5'd0);
        h_rd[1]  = if1.id_rd;
        h_lat[1] = (l == 0) ? 1 : ((l > D1) ? D1 : l);
    endtask

    initial begin
        logic           m_stall, m_take;
        logic [8:0]     m_sel;

        for (int k = 1; k <= D1; k++) begin
            h_v[k] = 1'b0; h_rd[k] = '0; h_lat[k] = 0;
        end
        drive0(0, 0, 0, 2'b00, 0, 0, 0, 0);
        if1.id_valid = 0; if1.id_src = '0; if1.id_src_used = '0; if1.id_rd = '0;
        if1.id_regwrite = 0; if1.id_lat = '0; if1.flush = 0;
        if2.id_valid = 0; if2.id_src = '0; if2.id_src_used = '0; if2.id_rd = '0;
        if2.id_regwrite = 0; if2.id_lat = '0; if2.flush = 0;

        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_u0_stall", 32'(if0.stall), 0);
        check("rst_u0_sel",   32'(if0.fwd_sel_q), 0);
        check("rst_u0_cnt",   32'(if0.stall_cnt), 0);
        check("rst_u1_sel",   32'(if1.fwd_sel_q), 0);
        check("rst_u2_cnt",   32'(if2.stall_cnt), 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU forward, load-use stall then forward from register 2
        step0("a_alu_rd3",    1, 0, 0,  2'b00, 3,  1, 1, 0, 0, 4'b0000);
        step0("b_use3",       1, 3, 0,  2'b01, 0,  0, 1, 0, 0, 4'b0001);
        step0("c_load_rd5",   1, 0, 0,  2'b00, 5,  1, 2, 0, 0, 4'b0000);
        step0("d_use5_stall", 1, 0, 5,  2'b10, 0,  0, 1, 0, 1, 4'b0000);
        step0("e_use5_fwd2",  1, 0, 5,  2'b10, 0,  0, 1, 0, 0, 4'b1000);
        check("cnt_after_e", 32'(if0.stall_cnt), 1);
        // youngest of two writers of the same tag wins
        step0("f_rd7",        1, 0, 0,  2'b00, 7,  1, 1, 0, 0, 4'b0000);
        step0("g_rd7",        1, 0, 0,  2'b00, 7,  1, 1, 0, 0, 4'b0000);
        step0("h_use7_young", 1, 7, 0,  2'b01, 0,  0, 1, 0, 0, 4'b0001);
        // two sources against two different producers
        step0("i_rd9",        1, 0, 0,  2'b00, 9,  1, 1, 0, 0, 4'b0000);
        step0("j_ld10",       1, 0, 0,  2'b00, 10, 1, 2, 0, 0, 4'b0000);
        step0("k_dual_stall", 1, 9, 10, 2'b11, 0,  0, 1, 0, 1, 4'b0000);
        step0("l_dual_fwd",   1, 9, 10, 2'b11, 0,  0, 1, 0, 0, 4'b1011);
        // tag 0 and flush
        step0("m_rd0",        1, 0, 0,  2'b00, 0,  1, 1, 0, 0, 4'b0000);
        step0("n_src0",       1, 0, 0,  2'b01, 0,  0, 1, 0, 0, 4'b0000);
        step0("o_ld12",       1, 0, 0,  2'b00, 12, 1, 2, 0, 0, 4'b0000);
        step0("p_flush",      1, 12, 0, 2'b01, 13, 1, 1, 1, 0, 4'b0000);
        step0("q_after_fl",   1, 13, 12, 2'b11, 0, 0, 1, 0, 0, 4'b1000);
        // latency 0 behaves as 1; latency DEPTH stalls twice; aged-out producer reads regfile
        step0("r_lat0",       1, 0, 0,  2'b00, 14, 1, 0, 0, 0, 4'b0000);
        step0("s_use14",      1, 14, 0, 2'b01, 0,  0, 1, 0, 0, 4'b0001);
        step0("t_lat3",       1, 0, 0,  2'b00, 15, 1, 3, 0, 0, 4'b0000);
        step0("u_stall1",     1, 0, 15, 2'b10, 0,  0, 1, 0, 1, 4'b0000);
        step0("v_stall2",     1, 0, 15, 2'b10, 0,  0, 1, 0, 1, 4'b0000);
        step0("w_fwd3",       1, 0, 15, 2'b10, 0,  0, 1, 0, 0, 4'b1100);
        step0("x_beyond",     1, 0, 15, 2'b10, 0,  0, 1, 0, 0, 4'b0000);
        check("cnt_after_x", 32'(if0.stall_cnt), 4);

        // reset in the middle of a load-use stall
        step0("y1_rd18",      1, 0, 0,  2'b00, 18, 1, 1, 0, 0, 4'b0000);
        step0("y2_ld17",      1, 18, 0, 2'b01, 17, 1, 2, 0, 0, 4'b0001);
        drive0(1, 17, 0, 2'b01, 0, 0, 1, 0);
        #1;
        check("z_stall_pre_rst", 32'(if0.stall), 1);
        reset_n = 1'b0;
        #1;
        check("z_rst_stall", 32'(if0.stall), 0);
        check("z_rst_sel",   32'(if0.fwd_sel_q), 0);
        check("z_rst_cnt",   32'(if0.stall_cnt), 0);
        @(negedge clk) reset_n = 1'b1;
        #1;
        check("z_post_stall", 32'(if0.stall), 0);
        q0.push_back('{tag: "z_post_sel", exp: 32'h0});
        tick();
        check("z_post_cnt", 32'(if0.stall_cnt), 0);
        drive0(0, 0, 0, 2'b00, 0, 0, 0, 0);

        // randomized sweep of the 3-source, 4-deep build
        for (int n = 0; n < 400; n++) begin
            if1.id_valid    = ($urandom_range(0, 7) != 0);
            if1.id_src      = {5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5))};
            if1.id_src_used = 3'($urandom_range(0, 7));
            if1.id_rd       = 5'($urandom_range(0, 5));
            if1.id_regwrite = ($urandom_range(0, 3) != 0);
            if1.id_lat      = 3'($urandom_range(0, 7));
            if1.flush       = ($urandom_range(0, 9) == 0);
            #1;
            model_eval(m_stall, m_take, m_sel);
            check($sformatf("sweep%0d_stall", n), 32'(if1.stall), 32'(m_stall));
            q1.push_back('{tag: $sformatf("sweep%0d_sel", n), exp: m_take ? 32'(m_sel) : 32'h0});
            tick();
            model_shift(m_take);
        end
        if1.id_valid = 0;

        // self-dependent latency-31 load: stalls 30 of every 31 cycles
        if2.id_valid = 1; if2.id_src = 5'd1; if2.id_src_used = 1'b1;
        if2.id_rd = 5'd1; if2.id_regwrite = 1; if2.id_lat = 5'd31; if2.flush = 0;
        #1;
        check("sat_t0_stall", 32'(if2.stall), 0);
        tick();
        check("sat_t1_stall", 32'(if2.stall), 1);
        repeat (99) tick();
        check("sat_cnt_100", 32'(if2.stall_cnt), 96);
        repeat (69900) tick();
        check("sat_cnt_final", 32'(if2.stall_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/forward_hazard_unit.md
FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter NSRC, default 2, source operands per instruction.
REQ-003 Parameter DEPTH, default 3, in-flight producer entries tracked (forwardable pipeline-register outputs 1..DEPTH).
REQ-004 Derived SEL_W = clog2(DEPTH+1); LAT_W = clog2(DEPTH+1).
REQ-005 clk  input  1  rising-edge clock, single domain.
REQ-006 reset_n  input  1  reset, asynchronous, active-low.
REQ-007 id_valid  input  1  decode-stage instruction present.
REQ-008 id_src  input  NSRC*ADDR_W  source register tags; operand i in bits [i*ADDR_W +: ADDR_W].
REQ-009 id_src_used  input  NSRC  per-source read-enable mask.
REQ-010 id_rd  input  ADDR_W  destination tag.
REQ-011 id_regwrite  input  1  instruction writes id_rd.
REQ-012 id_lat  input  LAT_W  result latency: pipeline-register index where the result first exists (ALU=1, load=2).
REQ-013 flush  input  1  kill decode-stage instruction this cycle.
REQ-014 stall  output  1  combinational; hold decode, insert EX bubble.
REQ-015 fwd_sel_q  output  NSRC*SEL_W  registered per-source bypass select for the EX cycle; 0 = register file, k = output of pipeline register k (1 = EX/MEM).
REQ-016 stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-017 Scoreboard SHALL hold DEPTH entries {v, rd, cnt}; entry j holds the producer issued j+1 cycles earlier (entry 0 = producer now in EX).
REQ-018 Match(i,j) SHALL be: id_src_used[i] & v[j] & rd[j]==src_i & src_i!=0; tag 0 never matches.
REQ-019 For each source, only the youngest matching entry (lowest j) SHALL be considered.
REQ-020 hazard_i SHALL be asserted when the youngest match has cnt[j] > 1.
REQ-021 stall SHALL equal id_valid & ~flush & OR(hazard_i).
REQ-022 Per source, next select SHALL be j+1 for the youngest match with cnt[j] <= 1, else 0.
REQ-023 Each rising edge: entry[j+1] <= entry[j] with cnt decremented, saturating at 0; entry[DEPTH-1] SHALL be discarded.
REQ-024 Entry 0 SHALL load v = id_valid & id_regwrite & (id_rd!=0) & ~stall & ~flush, rd = id_rd, cnt = id_lat clipped to 1..DEPTH (0 treated as 1).
REQ-025 fwd_sel_q SHALL load the REQ-022 selects when id_valid & ~stall & ~flush, else all zeros (bubble).
REQ-026 During stall, the scoreboard SHALL still shift; the held instruction SHALL be re-evaluated next cycle against the shifted state.
REQ-027 flush SHALL override stall; flushed instruction never enters the scoreboard.
REQ-028 stall_cnt SHALL increment on each cycle with stall=1, holding at 16'hFFFF.
REQ-029 Producers beyond DEPTH SHALL be served by the register file (write-before-read guaranteed externally).
REQ-030 Both sources matching different entries SHALL be resolved independently; stall if either hazards.

Reset
REQ-031 reset_n low SHALL asynchronously clear all v, rd, cnt, fwd_sel_q and stall_cnt to 0.
REQ-032 stall SHALL read 0 during reset, as all v=0.
REQ-033 Reset asserted mid-stall SHALL drop all in-flight entries; the first post-reset instruction sees no hazards.

Verification
REQ-034 ALU rd=3 lat=1, next cycle src0=3 -> stall=0, fwd_sel_q[src0]=1 next cycle.
REQ-035 Load rd=5 lat=2, next cycle src1=5 -> stall=1 one cycle, fwd_sel_q=0 (bubble); following cycle stall=0, fwd_sel_q[src1]=2.
REQ-036 Write rd=7 twice back-to-back (lat=1), then src0=7 -> fwd_sel_q[src0]=1 (youngest), not 2.
REQ-037 rd=0 with regwrite=1, then src0=0 -> no stall, select 0; load-use with flush=1 -> stall=0, no entry created.
REQ-038 Hold a load-use hazard, pulse reset_n low mid-stall -> all outputs 0 immediately; stall_cnt=0; then 70000 forced stall cycles -> stall_cnt=16'hFFFF.
REQ-039 Sweep NSRC=3, DEPTH=4 with random tags -> selects and stalls match a reference scoreboard model every cycle.
